// File: rtl/control_unit_fsm.sv
// Hardwired fetch/decode/execute sequencer for the ALU-system datapath.
// Optional HALT_INSN_EN: opcode 0x3F parks the sequencer in HALT until reset.
module control_unit_fsm #(
    parameter int OPC_W = 6,
    parameter int MAX_T = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALU_Flags,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted,
    output logic        Fault
);

    localparam int TW = $clog2(MAX_T + 2);

    localparam logic [OPC_W-1:0] OP_BRA  = OPC_W'('h00);
    localparam logic [OPC_W-1:0] OP_INC  = OPC_W'('h02);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'('h07);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'('h0C);
    localparam logic [OPC_W-1:0] OP_ORR  = OPC_W'('h0D);
    localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'('h0E);
    localparam logic [OPC_W-1:0] OP_MOVL = OPC_W'('h11);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'('h12);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'('h13);
`ifdef HALT_INSN_EN
    localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'('h3F);
`endif

    typedef enum logic [2:0] {
        S_CLR_PC,
        S_FETCH_L,
        S_FETCH_H,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state;
    logic [TW-1:0]   t_cnt;
    logic            fault_q;

    logic [OPC_W-1:0] opc;
    logic [2:0]       dst;
    logic [2:0]       src1;
    logic [2:0]       src2;
    logic [1:0]       rsel;
    logic             s_bit;
    logic             unused_flags;

    assign opc          = IROut[15 -: OPC_W];
    assign s_bit        = IROut[9];
    assign rsel         = IROut[9:8];
    assign dst          = IROut[8:6];
    assign src1         = IROut[5:3];
    assign src2         = IROut[2:0];
    assign unused_flags = ^ALU_Flags;

    logic t2;
    logic t3;
    logic is_bra;
    logic is_inc;
    logic is_alu;
    logic is_movl;
    logic is_ld;
    logic is_st;
    logic halt_op;
    logic exec_done;
    logic [4:0] alu_code;

    assign t2      = (t_cnt == TW'(2));
    assign t3      = (t_cnt == TW'(3));
    assign is_bra  = (opc == OP_BRA);
    // Register fields must use the 1xx encoding, otherwise the op is a NOP
    assign is_inc  = (opc == OP_INC) && dst[2] && src1[2];
    assign is_alu  = (opc inside {OP_ADD, OP_AND, OP_ORR, OP_XOR})
                     && dst[2] && src1[2] && src2[2];
    assign is_movl = (opc == OP_MOVL);
    assign is_ld   = (opc == OP_LD);
    assign is_st   = (opc == OP_ST);
    assign exec_done = !(is_inc && t2);

`ifdef HALT_INSN_EN
    assign halt_op = (opc == OP_HLT);
    assign Halted  = !Reset && (state == S_HALT);
`else
    assign halt_op = 1'b0;
    assign Halted  = 1'b0;
`endif

    assign Fault = fault_q;

    always_comb begin
        alu_code = 5'b11001;
        unique case (opc)
            OP_ADD:  alu_code = 5'b10100;
            OP_AND:  alu_code = 5'b10111;
            OP_ORR:  alu_code = 5'b11000;
            default: alu_code = 5'b11001;
        endcase
    end

    function automatic logic [3:0] reg_hot(input logic [1:0] idx);
        logic [3:0] r;
        unique case (idx)
            2'd0:    r = 4'b1000;
            2'd1:    r = 4'b0100;
            2'd2:    r = 4'b0010;
            default: r = 4'b0001;
        endcase
        return r;
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= S_CLR_PC;
            t_cnt   <= '0;
            fault_q <= 1'b0;
        end else begin
            unique case (state)
                S_CLR_PC: begin
                    state <= S_FETCH_L;
                    t_cnt <= '0;
                end
                S_FETCH_L: begin
                    state <= S_FETCH_H;
                    t_cnt <= TW'(1);
                end
                S_FETCH_H: begin
                    state <= S_EXEC;
                    t_cnt <= TW'(2);
                end
                S_EXEC: begin
                    if (halt_op) begin
                        state <= S_HALT;
                        t_cnt <= '0;
                    end else if (exec_done) begin
                        state <= S_FETCH_L;
                        t_cnt <= '0;
                    end else if (t_cnt >= TW'(MAX_T)) begin
                        fault_q <= 1'b1;
                        state   <= S_FETCH_L;
                        t_cnt   <= '0;
                    end else begin
                        t_cnt <= t_cnt + TW'(1);
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_CLR_PC;
                    t_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = 3'b000;
        RF_RegSel   = 4'b0000;
        RF_ScrSel   = 4'b0000;
        ALU_FunSel  = 5'b00000;
        ALU_WF      = 1'b0;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 3'b000;
        ARF_RegSel  = 3'b000;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        if (!Reset) begin
            unique case (state)
                S_CLR_PC: begin
                    ARF_RegSel = 3'b100;
                    ARF_FunSel = 3'b011;
                end
                S_FETCH_L, S_FETCH_H: begin
                    ARF_OutDSel = 2'b00;
                    Mem_CS      = 1'b0;
                    IR_Write    = 1'b1;
                    IR_LH       = (state == S_FETCH_H);
                    ARF_RegSel  = 3'b100;
                    ARF_FunSel  = 3'b001;
                end
                S_EXEC: begin
                    unique case (1'b1)
                        t2 && is_bra: begin
                            MuxBSel    = 2'b11;
                            ARF_RegSel = 3'b100;
                            ARF_FunSel = 3'b010;
                        end
                        t2 && is_inc: begin
                            RF_OutASel = {1'b0, src1[1:0]};
                            ALU_FunSel = 5'b10000;
                            RF_FunSel  = 3'b010;
                            RF_RegSel  = reg_hot(dst[1:0]);
                        end
                        t3 && is_inc: begin
                            RF_FunSel = 3'b001;
                            RF_RegSel = reg_hot(dst[1:0]);
                        end
                        t2 && is_alu: begin
                            RF_OutASel = {1'b0, src1[1:0]};
                            RF_OutBSel = {1'b0, src2[1:0]};
                            ALU_FunSel = alu_code;
                            RF_FunSel  = 3'b010;
                            RF_RegSel  = reg_hot(dst[1:0]);
                            ALU_WF     = s_bit;
                        end
                        t2 && is_movl: begin
                            MuxASel   = 2'b11;
                            RF_FunSel = 3'b100;
                            RF_RegSel = reg_hot(rsel);
                        end
                        t2 && is_ld: begin
                            ARF_OutDSel = 2'b10;
                            Mem_CS      = 1'b0;
                            MuxASel     = 2'b10;
                            RF_FunSel   = 3'b100;
                            RF_RegSel   = reg_hot(rsel);
                        end
                        t2 && is_st: begin
                            ARF_OutDSel = 2'b10;
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b1;
                            RF_OutASel  = {1'b0, rsel};
                            ALU_FunSel  = 5'b10000;
                            MuxCSel     = 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Randomised bench for control_unit_fsm against an instruction-level model.
// Build with +define+HALT_INSN_EN to cover the HALT opcode variant.
module tb_control_unit_fsm;

    typedef struct packed {
        logic [2:0] oa;
        logic [2:0] ob;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] arf_c;
        logic [1:0] arf_d;
        logic [2:0] arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh;
        logic       ir_wr;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
        logic       halted;
        logic       fault;
    } ctrl_t;

    logic        Clock;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALU_Flags;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted, Fault;

    control_unit_fsm dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALU_Flags(ALU_Flags),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel),
        .RF_FunSel(RF_FunSel), .RF_RegSel(RF_RegSel),
        .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
        .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR),
        .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
        .MuxCSel(MuxCSel), .Halted(Halted), .Fault(Fault)
    );

    ctrl_t dut_v;
    assign dut_v = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
                    ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
                    ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxASel,
                    MuxBSel, MuxCSel, Halted, Fault};

    int    errors = 0;
    int    checks = 0;
    ctrl_t exp_v;
    string tag = "reset";
    bit    chk_en = 1'b0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (chk_en) begin
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL %s t=%0t got=%h want=%h ir=%h",
                         tag, $time, dut_v, exp_v, IROut);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic ctrl_t idle_v();
        ctrl_t v = '0;
        v.mem_cs = 1'b1;
        return v;
    endfunction

    function automatic ctrl_t clr_v();
        ctrl_t v = idle_v();
        v.arf_reg = 3'b100;
        v.arf_fun = 3'b011;
        return v;
    endfunction

    function automatic ctrl_t fetch_v(input bit hi);
        ctrl_t v = idle_v();
        v.mem_cs  = 1'b0;
        v.ir_wr   = 1'b1;
        v.ir_lh   = hi;
        v.arf_reg = 3'b100;
        v.arf_fun = 3'b001;
        return v;
    endfunction

    // Instruction-level model: number of exec cycles and their vectors
    task automatic exec_model(input logic [15:0] ir, output int n,
                              output ctrl_t v0, output ctrl_t v1);
        int opc = int'(ir[15:10]);
        int d   = int'(ir[8:6]);
        int a   = int'(ir[5:3]);
        int b   = int'(ir[2:0]);
        int r   = int'(ir[9:8]);
        bit ok2 = (d >= 4) && (a >= 4);
        bit ok3 = ok2 && (b >= 4);
        n  = 1;
        v0 = idle_v();
        v1 = idle_v();
        case (opc)
            0: begin
                v0.mux_b   = 2'b11;
                v0.arf_reg = 3'b100;
                v0.arf_fun = 3'b010;
            end
            2: if (ok2) begin
                n = 2;
                v0.oa      = 3'(a - 4);
                v0.alu_fun = 5'd16;
                v0.rf_fun  = 3'd2;
                v0.rf_reg  = 4'(8 >> (d - 4));
                v1.rf_fun  = 3'd1;
                v1.rf_reg  = 4'(8 >> (d - 4));
            end
            7, 12, 13, 14: if (ok3) begin
                v0.oa      = 3'(a - 4);
                v0.ob      = 3'(b - 4);
                v0.alu_fun = (opc == 7) ? 5'd20 : (opc == 12) ? 5'd23 :
                             (opc == 13) ? 5'd24 : 5'd25;
                v0.rf_fun  = 3'd2;
                v0.rf_reg  = 4'(8 >> (d - 4));
                v0.alu_wf  = ir[9];
            end
            17: begin
                v0.mux_a  = 2'd3;
                v0.rf_fun = 3'd4;
                v0.rf_reg = 4'(8 >> r);
            end
            18: begin
                v0.arf_d  = 2'd2;
                v0.mem_cs = 1'b0;
                v0.mux_a  = 2'd2;
                v0.rf_fun = 3'd4;
                v0.rf_reg = 4'(8 >> r);
            end
            19: begin
                v0.arf_d   = 2'd2;
                v0.mem_cs  = 1'b0;
                v0.mem_wr  = 1'b1;
                v0.oa      = 3'(r);
                v0.alu_fun = 5'd16;
            end
            default: begin
            end
        endcase
    endtask

    task automatic begin_cycle(input ctrl_t e, input string tg);
        exp_v = e;
        tag   = tg;
        #2;
    endtask

    task automatic end_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic cyc(input ctrl_t e, input string tg);
        begin_cycle(e, tg);
        end_cycle();
    endtask

    task automatic fetch(input logic [15:0] ir);
        IROut     = ir;
        ALU_Flags = 4'($urandom);
        begin_cycle(fetch_v(1'b0), "fetch_l");
        lit("fetch_l_irw", 32'(IR_Write), 32'd1);
        lit("fetch_l_lh", 32'(IR_LH), 32'd0);
        end_cycle();
        cyc(fetch_v(1'b1), "fetch_h");
    endtask

    task automatic run_insn(input logic [15:0] ir);
        int    n;
        ctrl_t v0, v1;
        exec_model(ir, n, v0, v1);
        fetch(ir);
        cyc(v0, "exec_t2");
        if (n == 2) cyc(v1, "exec_t3");
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc(idle_v(), "rst_hold");
        Reset = 1'b0;
        begin_cycle(clr_v(), "clr_pc");
        lit("clr_arf_reg", 32'(ARF_RegSel), 32'b100);
        lit("clr_arf_fun", 32'(ARF_FunSel), 32'b011);
        end_cycle();
    endtask

    int    n;
    ctrl_t v0, v1;
    int    opcs[9] = '{0, 2, 7, 12, 13, 14, 17, 18, 19};

    initial begin
        Reset     = 1'b1;
        IROut     = 16'h0000;
        ALU_Flags = 4'h0;
        exp_v     = idle_v();
        chk_en    = 1'b1;
        #3;
        lit("rst_mem_cs", 32'(Mem_CS), 32'd1);
        lit("rst_rf_reg", 32'(RF_RegSel), 32'd0);
        lit("rst_arf_reg", 32'(ARF_RegSel), 32'd0);
        lit("rst_fault", 32'(Fault), 32'd0);
        end_cycle();
        do_reset();

        // ADD S=1 R2 <- R3 + R4
        exec_model(16'h1F77, n, v0, v1);
        fetch(16'h1F77);
        begin_cycle(v0, "add_t2");
        lit("add_fun", 32'(ALU_FunSel), 32'b10100);
        lit("add_oa", 32'(RF_OutASel), 32'b010);
        lit("add_ob", 32'(RF_OutBSel), 32'b011);
        lit("add_reg", 32'(RF_RegSel), 32'b0100);
        lit("add_wf", 32'(ALU_WF), 32'd1);
        end_cycle();

        // INC R3 <- R3 + 1
        exec_model(16'h09B0, n, v0, v1);
        fetch(16'h09B0);
        begin_cycle(v0, "inc_t2");
        lit("inc_t2_fun", 32'(RF_FunSel), 32'b010);
        lit("inc_t2_reg", 32'(RF_RegSel), 32'b0010);
        end_cycle();
        begin_cycle(v1, "inc_t3");
        lit("inc_t3_fun", 32'(RF_FunSel), 32'b001);
        lit("inc_t3_reg", 32'(RF_RegSel), 32'b0010);
        end_cycle();

        // ST from R2
        exec_model(16'h4D5A, n, v0, v1);
        fetch(16'h4D5A);
        begin_cycle(v0, "st_t2");
        lit("st_cs", 32'(Mem_CS), 32'd0);
        lit("st_wr", 32'(Mem_WR), 32'd1);
        lit("st_outd", 32'(ARF_OutDSel), 32'b10);
        lit("st_muxc", 32'(MuxCSel), 32'd0);
        lit("st_n", 32'(n), 32'd1);
        end_cycle();

        // Illegal register fields execute as NOP
        foreach (opcs[k]) begin
            if (k == 0) begin
                fetch(16'h1C13);
                begin_cycle(idle_v(), "add_bad_dst");
                lit("bad_dst_reg", 32'(RF_RegSel), 32'd0);
                lit("bad_dst_wf", 32'(ALU_WF), 32'd0);
                end_cycle();
                fetch(16'h1F57);
                begin_cycle(idle_v(), "add_bad_src1");
                lit("bad_src1_reg", 32'(RF_RegSel), 32'd0);
                lit("bad_src1_wf", 32'(ALU_WF), 32'd0);
                end_cycle();
            end
        end

        // Reset asserted in the middle of INC's first exec cycle
        exec_model(16'h09B0, n, v0, v1);
        fetch(16'h09B0);
        begin_cycle(idle_v(), "rst_mid");
        Reset = 1'b1;
        #1;
        lit("rst_mid_reg", 32'(RF_RegSel), 32'd0);
        lit("rst_mid_fun", 32'(RF_FunSel), 32'd0);
        lit("rst_mid_cs", 32'(Mem_CS), 32'd1);
        end_cycle();
        do_reset();

        for (int i = 0; i < 150; i++) begin
            logic [5:0]  op;
            logic [15:0] ir;
            if ($urandom_range(0, 11) < 9)
                op = 6'(opcs[$urandom_range(0, 8)]);
            else
                op = 6'($urandom_range(0, 62));
            ir = {op, 10'($urandom)};
            if ($urandom_range(0, 3) != 0)
                ir = ir | 16'h0124;
            run_insn(ir);
        end

`ifdef HALT_INSN_EN
        fetch(16'hFC00);
        cyc(idle_v(), "halt_t2");
        for (int i = 0; i < 20; i++) begin
            v0        = idle_v();
            v0.halted = 1'b1;
            begin_cycle(v0, "halted");
            lit("halted_hold", 32'(Halted), 32'd1);
            end_cycle();
        end
        do_reset();
        run_insn(16'h1F77);
`else
        fetch(16'hFC00);
        cyc(idle_v(), "nop_3f");
        begin_cycle(fetch_v(1'b0), "after_3f");
        lit("after_3f_irw", 32'(IR_Write), 32'd1);
        lit("after_3f_halt", 32'(Halted), 32'd0);
        end_cycle();
        cyc(fetch_v(1'b1), "fetch_h");
        IROut = 16'h1F77;
        exec_model(16'h1F77, n, v0, v1);
        cyc(v0, "exec_t2");
`endif
        run_insn(16'h4D5A);
        lit("fault_end", 32'(Fault), 32'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
